// File: rtl/multicycle_ctrl_unit_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multi-cycle MIPS-subset controller:
//   - state encodings (state_t)
//   - opcode / func constants, ALUC codes, PCSource codes
//   - ctrl_t: the bundle of datapath controls registered by the FSM
//   - helper functions: next_state, ctrl_for, insn_supported
// Build option: CTRL_ADDI_EN -- when defined, addi (op 001000) is a
// supported instruction and uses states EX_I / WB_I. When undefined, addi
// decodes as unsupported and states 10/11 behave as illegal encodings.
// ---------------------------------------------------------------------------
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF        = 4'd0,
      S_ID        = 4'd1,
      S_EX_R      = 4'd2,
      S_EX_MEMADR = 4'd3,
      S_MEM_RD    = 4'd4,
      S_MEM_WR    = 4'd5,
      S_WB_R      = 4'd6,
      S_WB_LW     = 4'd7,
      S_EX_BEQ    = 4'd8,
      S_EX_J      = 4'd9,
      S_EX_I      = 4'd10,
      S_WB_I      = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [5:0] FUNC_ADD = 6'b100000;
   localparam logic [5:0] FUNC_SUB = 6'b100010;
   localparam logic [5:0] FUNC_AND = 6'b100100;
   localparam logic [5:0] FUNC_OR  = 6'b100101;
   localparam logic [5:0] FUNC_SLT = 6'b101010;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   localparam logic [1:0] PCSRC_SEQ    = 2'b00;
   localparam logic [1:0] PCSRC_BRANCH = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

`ifdef CTRL_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   // Registered controls; 'stage' marks the last state of an instruction.
   typedef struct packed {
      logic       write_pc;
      logic       iord;
      logic       write_mem;
      logic       write_dr;
      logic       write_ir;
      logic       mem_to_reg;
      logic       reg_dst;
      logic [1:0] pc_source;
      logic       write_c;
      logic [2:0] aluc;
      logic       alu_src_a;
      logic       alu_src_b;
      logic       write_a;
      logic       write_b;
      logic       write_reg;
      logic       stage;
   } ctrl_t;

   function automatic logic insn_supported(input logic [5:0] op,
                                           input logic       func_ok);
      case (op)
         OP_RTYPE:                   return func_ok;
         OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
         OP_ADDI:                    return ADDI_EN;
         default:                    return 1'b0;
      endcase
   endfunction

   // Anything unreachable or illegal (12-15, and 10/11 without addi)
   // falls back to IF.
   function automatic state_t next_state(input state_t     s,
                                         input logic [5:0] op,
                                         input logic       func_ok);
      case (s)
         S_IF: return S_ID;
         S_ID: begin
            if (!insn_supported(op, func_ok)) return S_IF;
            case (op)
               OP_RTYPE:     return S_EX_R;
               OP_LW, OP_SW: return S_EX_MEMADR;
               OP_BEQ:       return S_EX_BEQ;
               OP_J:         return S_EX_J;
               OP_ADDI:      return S_EX_I;
               default:      return S_IF;
            endcase
         end
         S_EX_R:      return S_WB_R;
         S_EX_MEMADR: return (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:    return S_WB_LW;
         S_EX_I:      return ADDI_EN ? S_WB_I : S_IF;
         default:     return S_IF;
      endcase
   endfunction

   // Moore control values for a state; alu_r is the decoded R-type ALUC.
   function automatic ctrl_t ctrl_for(input state_t     s,
                                      input logic [2:0] alu_r);
      ctrl_t c;
      c = '0;
      case (s)
         S_IF: begin
            c.write_ir  = 1'b1;
            c.write_pc  = 1'b1;
            c.pc_source = PCSRC_SEQ;
         end
         S_ID: begin
            c.write_a = 1'b1;
            c.write_b = 1'b1;
         end
         S_EX_R: begin
            c.alu_src_a = 1'b1;
            c.aluc      = alu_r;
            c.write_c   = 1'b1;
         end
         S_WB_R: begin
            c.reg_dst   = 1'b1;
            c.write_reg = 1'b1;
            c.stage     = 1'b1;
         end
         S_EX_MEMADR: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 1'b1;
            c.aluc      = ALUC_ADD;
            c.write_c   = 1'b1;
         end
         S_MEM_RD: begin
            c.iord     = 1'b1;
            c.write_dr = 1'b1;
         end
         S_WB_LW: begin
            c.mem_to_reg = 1'b1;
            c.write_reg  = 1'b1;
            c.stage      = 1'b1;
         end
         S_MEM_WR: begin
            c.iord      = 1'b1;
            c.write_mem = 1'b1;
            c.stage     = 1'b1;
         end
         // WritePC here depends on Zero and is added outside the register.
         S_EX_BEQ: begin
            c.alu_src_a = 1'b1;
            c.aluc      = ALUC_SUB;
            c.pc_source = PCSRC_BRANCH;
            c.stage     = 1'b1;
         end
         S_EX_J: begin
            c.pc_source = PCSRC_JUMP;
            c.write_pc  = 1'b1;
            c.stage     = 1'b1;
         end
         S_EX_I: begin
            if (ADDI_EN) begin
               c.alu_src_a = 1'b1;
               c.alu_src_b = 1'b1;
               c.aluc      = ALUC_ADD;
               c.write_c   = 1'b1;
            end
         end
         S_WB_I: begin
            if (ADDI_EN) begin
               c.write_reg = 1'b1;
               c.stage     = 1'b1;
            end
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/multicycle_ctrl_unit_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_unit_if
// Controller <-> datapath bundle.
//   From datapath: op, func (instruction register fields), Zero (ALU flag)
//   To datapath:   write enables, mux selects, ALUC
//   Debug:         state_out, insn_type, insn_code, insn_stage
// Modports: master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_unit_if;
   logic [5:0] op;
   logic [5:0] func;
   logic       Zero;
   logic       WritePC;
   logic       IorD;
   logic       WriteMem;
   logic       WriteDR;
   logic       WriteIR;
   logic       MemToReg;
   logic       RegDst;
   logic [1:0] PCSource;
   logic       WriteC;
   logic [2:0] ALUC;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic       WriteA;
   logic       WriteB;
   logic       WriteReg;
   logic [3:0] state_out;
   logic       insn_type;
   logic       insn_code;
   logic       insn_stage;

   modport master (
      input  op, func, Zero,
      output WritePC, IorD, WriteMem, WriteDR, WriteIR, MemToReg, RegDst,
             PCSource, WriteC, ALUC, ALUSrcA, ALUSrcB, WriteA, WriteB,
             WriteReg, state_out, insn_type, insn_code, insn_stage
   );

   modport slave (
      output op, func, Zero,
      input  WritePC, IorD, WriteMem, WriteDR, WriteIR, MemToReg, RegDst,
             PCSource, WriteC, ALUC, ALUSrcA, ALUSrcB, WriteA, WriteB,
             WriteReg, state_out, insn_type, insn_code, insn_stage
   );
endinterface

// File: rtl/multicycle_ctrl_unit_alu_ctrl_dec.sv
// ---------------------------------------------------------------------------
// alu_ctrl_dec
// R-type function decoder.
//   func    in  6  IR[5:0]
//   aluc    out 3  ALU operation for the func
//   func_ok out 1  func is one of add/sub/and/or/slt
// ---------------------------------------------------------------------------
module alu_ctrl_dec
   import ctrl_pkg::*;
(
   input  logic [5:0] func,
   output logic [2:0] aluc,
   output logic       func_ok
);

   always_comb begin
      aluc    = ALUC_ADD;
      func_ok = 1'b1;
      case (func)
         FUNC_ADD: aluc = ALUC_ADD;
         FUNC_SUB: aluc = ALUC_SUB;
         FUNC_AND: aluc = ALUC_AND;
         FUNC_OR:  aluc = ALUC_OR;
         FUNC_SLT: aluc = ALUC_SLT;
         default:  func_ok = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_unit.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_unit
// Moore FSM controller for a multi-cycle MIPS-subset CPU (IF/ID/EX/MEM/WB).
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset; forces all write enables low
//   bus  multicycle_ctrl_unit_if.master: op/func/Zero in, controls and
//        debug status (state_out, insn_type, insn_code, insn_stage) out
// Build option: CTRL_ADDI_EN enables addi (see ctrl_pkg).
// ---------------------------------------------------------------------------
module multicycle_ctrl_unit
   import ctrl_pkg::*;
(
   input logic                   clk,
   input logic                   rst,
   multicycle_ctrl_unit_if.master bus
);

   state_t     state;
   state_t     state_nx;
   ctrl_t      ctrl_q;
   logic [2:0] alu_r;
   logic       func_ok;
   logic       code_ok;

   alu_ctrl_dec u_alu_ctrl_dec (
      .func    (bus.func),
      .aluc    (alu_r),
      .func_ok (func_ok)
   );

   assign code_ok  = insn_supported(bus.op, func_ok);
   assign state_nx = next_state(state, bus.op, func_ok);

   // Controls are registered alongside the state, computed from the
   // state being entered, so they are glitch-free Moore outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IF;
         ctrl_q <= ctrl_for(S_IF, ALUC_ADD);
      end else begin
         state  <= state_nx;
         ctrl_q <= ctrl_for(state_nx, alu_r);
      end
   end

   // Write enables are masked by rst so nothing is written while in reset.
   assign bus.WritePC    = ~rst & (ctrl_q.write_pc | ((state == S_EX_BEQ) & bus.Zero));
   assign bus.WriteMem   = ~rst & ctrl_q.write_mem;
   assign bus.WriteDR    = ~rst & ctrl_q.write_dr;
   assign bus.WriteIR    = ~rst & ctrl_q.write_ir;
   assign bus.WriteC     = ~rst & ctrl_q.write_c;
   assign bus.WriteA     = ~rst & ctrl_q.write_a;
   assign bus.WriteB     = ~rst & ctrl_q.write_b;
   assign bus.WriteReg   = ~rst & ctrl_q.write_reg;

   assign bus.IorD       = ctrl_q.iord;
   assign bus.MemToReg   = ctrl_q.mem_to_reg;
   assign bus.RegDst     = ctrl_q.reg_dst;
   assign bus.PCSource   = ctrl_q.pc_source;
   assign bus.ALUC       = ctrl_q.aluc;
   assign bus.ALUSrcA    = ctrl_q.alu_src_a;
   assign bus.ALUSrcB    = ctrl_q.alu_src_b;

   assign bus.state_out  = state;
   assign bus.insn_type  = (bus.op == OP_RTYPE);
   assign bus.insn_code  = code_ok;
   // An unsupported instruction ends in ID.
   assign bus.insn_stage = ctrl_q.stage | ((state == S_ID) & ~code_ok);

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_unit
// Self-checking bench for multicycle_ctrl_unit. Each instruction is expanded
// by a reference model into the list of states it visits and the controls
// expected in each, then the DUT is stepped and compared cycle by cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_unit;

`ifdef CTRL_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   typedef struct packed {
      logic [3:0]  st;
      logic [17:0] ctl;
      logic        stage;
   } step_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;
   step_t       expq[$];
   logic [17:0] we_mask;
   logic [17:0] if_ctl;

   multicycle_ctrl_unit_if bus ();

   multicycle_ctrl_unit dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Packs the control outputs in a fixed order for comparison.
   function automatic logic [17:0] ctl(
      input logic wpc, iord, wmem, wdr, wir, m2r, rdst,
      input logic [1:0] pcs,
      input logic wc,
      input logic [2:0] aluc,
      input logic srca, srcb, wa, wb, wreg);
      return {wpc, iord, wmem, wdr, wir, m2r, rdst, pcs, wc, aluc,
              srca, srcb, wa, wb, wreg};
   endfunction

   function automatic logic [17:0] obs_ctl();
      return ctl(bus.WritePC, bus.IorD, bus.WriteMem, bus.WriteDR,
                 bus.WriteIR, bus.MemToReg, bus.RegDst, bus.PCSource,
                 bus.WriteC, bus.ALUC, bus.ALUSrcA, bus.ALUSrcB,
                 bus.WriteA, bus.WriteB, bus.WriteReg);
   endfunction

   function automatic step_t mk(input logic [3:0] st, input logic [17:0] c,
                                input logic stg);
      return {st, c, stg};
   endfunction

   function automatic logic ref_func_ok(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] ref_aluc(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b000;
      endcase
   endfunction

   function automatic logic ref_supported(input logic [5:0] op,
                                          input logic [5:0] f);
      if (op == 6'b000000) return ref_func_ok(f);
      if (op inside {6'b100011, 6'b101011, 6'b000100, 6'b000010}) return 1'b1;
      if (op == 6'b001000) return ADDI_EN;
      return 1'b0;
   endfunction

   // Expands one instruction into its expected per-cycle behaviour.
   task automatic build_expected(input logic [5:0] op, input logic [5:0] f,
                                 input logic z);
      logic sup;
      sup = ref_supported(op, f);
      expq.delete();
      expq.push_back(mk(4'd0, if_ctl, 1'b0));
      expq.push_back(mk(4'd1, ctl(0,0,0,0,0,0,0,2'b00,0,3'b000,0,0,1,1,0), ~sup));
      if (sup) begin
         case (op)
            6'b000000: begin
               expq.push_back(mk(4'd2, ctl(0,0,0,0,0,0,0,2'b00,1,ref_aluc(f),1,0,0,0,0), 1'b0));
               expq.push_back(mk(4'd6, ctl(0,0,0,0,0,0,1,2'b00,0,3'b000,0,0,0,0,1), 1'b1));
            end
            6'b100011: begin
               expq.push_back(mk(4'd3, ctl(0,0,0,0,0,0,0,2'b00,1,3'b010,1,1,0,0,0), 1'b0));
               expq.push_back(mk(4'd4, ctl(0,1,0,1,0,0,0,2'b00,0,3'b000,0,0,0,0,0), 1'b0));
               expq.push_back(mk(4'd7, ctl(0,0,0,0,0,1,0,2'b00,0,3'b000,0,0,0,0,1), 1'b1));
            end
            6'b101011: begin
               expq.push_back(mk(4'd3, ctl(0,0,0,0,0,0,0,2'b00,1,3'b010,1,1,0,0,0), 1'b0));
               expq.push_back(mk(4'd5, ctl(0,1,1,0,0,0,0,2'b00,0,3'b000,0,0,0,0,0), 1'b1));
            end
            6'b000100:
               expq.push_back(mk(4'd8, ctl(z,0,0,0,0,0,0,2'b01,0,3'b110,1,0,0,0,0), 1'b1));
            6'b000010:
               expq.push_back(mk(4'd9, ctl(1,0,0,0,0,0,0,2'b10,0,3'b000,0,0,0,0,0), 1'b1));
            default: begin
               expq.push_back(mk(4'd10, ctl(0,0,0,0,0,0,0,2'b00,1,3'b010,1,1,0,0,0), 1'b0));
               expq.push_back(mk(4'd11, ctl(0,0,0,0,0,0,0,2'b00,0,3'b000,0,0,0,0,1), 1'b1));
            end
         endcase
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed=%0h expected=%0h (t=%0t)",
                  tag, observed, expected, $time);
      end
   endtask

   // Runs one instruction starting just after an edge that entered IF.
   // abort_at >= 0 raises rst while in that step of the instruction.
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] f,
                                input logic z, input int abort_at);
      bus.op   = op;
      bus.func = f;
      bus.Zero = z;
      build_expected(op, f, z);
      #1;
      for (int i = 0; i < expq.size(); i++) begin
         if (i > 0) begin
            @(posedge clk);
            #1;
         end
         checkOutput("state", {28'd0, bus.state_out}, {28'd0, expq[i].st});
         checkOutput("ctl", {14'd0, obs_ctl()}, {14'd0, expq[i].ctl});
         checkOutput("stage", {31'd0, bus.insn_stage}, {31'd0, expq[i].stage});
         if (i == 1) begin
            checkOutput("insn_type", {31'd0, bus.insn_type}, {31'd0, (op == 6'b000000)});
            checkOutput("insn_code", {31'd0, bus.insn_code}, {31'd0, ref_supported(op, f)});
         end
         if (i == abort_at) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("rst_state", {28'd0, bus.state_out}, 32'd0);
            checkOutput("rst_we", {14'd0, obs_ctl() & we_mask}, 32'd0);
            rst = 1'b0;
            #1;
            checkOutput("rel_state", {28'd0, bus.state_out}, 32'd0);
            checkOutput("rel_ctl", {14'd0, obs_ctl()}, {14'd0, if_ctl});
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [5:0] op;
      logic [5:0] f;
      int         sel;
      int         abort_at;
      checks   = 0;
      failures = 0;
      we_mask  = ctl(1,0,1,1,1,0,0,2'b00,1,3'b000,0,0,1,1,1);
      if_ctl   = ctl(1,0,0,0,1,0,0,2'b00,0,3'b000,0,0,0,0,0);
      rst      = 1'b1;
      bus.op   = 6'd0;
      bus.func = 6'd0;
      bus.Zero = 1'b0;

      @(posedge clk);
      #1;
      checkOutput("reset_state", {28'd0, bus.state_out}, 32'd0);
      checkOutput("reset_we", {14'd0, obs_ctl() & we_mask}, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("if_state", {28'd0, bus.state_out}, 32'd0);
      checkOutput("if_ctl", {14'd0, obs_ctl()}, {14'd0, if_ctl});

      applyStimulus(6'b000000, 6'b100000, 1'b0, -1);
      applyStimulus(6'b000000, 6'b101010, 1'b1, -1);
      applyStimulus(6'b100011, 6'b000000, 1'b0, -1);
      applyStimulus(6'b101011, 6'b000000, 1'b0, -1);
      applyStimulus(6'b000100, 6'b000000, 1'b1, -1);
      applyStimulus(6'b000100, 6'b000000, 1'b0, -1);
      applyStimulus(6'b000010, 6'b000000, 1'b0, -1);
      applyStimulus(6'b111111, 6'b000000, 1'b0, -1);
      applyStimulus(6'b000000, 6'b111111, 1'b0, -1);
      applyStimulus(6'b001000, 6'b000000, 1'b0, -1);
      applyStimulus(6'b100011, 6'b000000, 1'b0, 3);

      for (int n = 0; n < 300; n++) begin
         sel = $urandom_range(0, 7);
         f   = 6'($urandom_range(0, 63));
         case (sel)
            0, 1: begin
               op = 6'b000000;
               if ($urandom_range(0, 3) != 0) begin
                  case ($urandom_range(0, 4))
                     0: f = 6'b100000;
                     1: f = 6'b100010;
                     2: f = 6'b100100;
                     3: f = 6'b100101;
                     default: f = 6'b101010;
                  endcase
               end
            end
            2: op = 6'b100011;
            3: op = 6'b101011;
            4: op = 6'b000100;
            5: op = 6'b000010;
            6: op = 6'b001000;
            default: op = 6'($urandom_range(0, 63));
         endcase
         abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
         applyStimulus(op, f, 1'($urandom_range(0, 1)), abort_at);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_unit.md
Name: multicycle_ctrl_unit

Overview:
Moore-style FSM controller for a multi-cycle MIPS-subset CPU. It sequences each instruction through IF/ID/EX/MEM/WB states and drives every datapath write-enable and mux select. It sits beside the datapath and reads op/func from the instruction register and Zero from the ALU. It also exports its state and instruction-status flags for debug.

Parameters:
none (all encodings are package constants)

Ports:
clk  in  1  system clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
op  in  6  IR[31:26]
func  in  6  IR[5:0]
Zero  in  1  ALU zero flag
WritePC  out  1  PC write enable
IorD  out  1  memory address select: 0=PC, 1=ALU-out register C
WriteMem  out  1  memory write enable
WriteDR  out  1  data register load
WriteIR  out  1  instruction register load
MemToReg  out  1  register write data: 0=C, 1=DR
RegDst  out  1  destination register: 0=rt, 1=rd
PCSource  out  2  00=PC+4, 01=branch target (PC+4+imm<<2), 10=jump target, 11=C
WriteC  out  1  ALU-out register load
ALUC  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  1  0=B, 1=sign-extended imm
WriteA  out  1  A register load
WriteB  out  1  B register load
WriteReg  out  1  register file write enable
state_out  out  4  current state encoding
insn_type  out  1  1 when op==000000 (R-type)
insn_code  out  1  1 when op/func is a supported instruction
insn_stage  out  1  1 in the final state of the current instruction

Behaviour:
- States (4-bit): IF=0, ID=1, EX_R=2, EX_MEMADR=3, MEM_RD=4, MEM_WR=5, WB_R=6, WB_LW=7, EX_BEQ=8, EX_J=9, EX_I=10, WB_I=11. Encodings 12-15 are illegal and go to IF.
- Reset: state<=IF. While rst=1, all write enables (WritePC, WriteMem, WriteDR, WriteIR, WriteC, WriteA, WriteB, WriteReg) are forced to 0.
- Any output not listed for a state is 0.
- IF: IorD=0, WriteIR=1, WritePC=1, PCSource=00. Next state is ID.
- ID: WriteA=1, WriteB=1. Decode:
  - R-type with a supported func -> EX_R
  - lw(100011) or sw(101011) -> EX_MEMADR
  - beq(000100) -> EX_BEQ
  - j(000010) -> EX_J
  - addi(001000) -> EX_I
  - anything else -> IF; executes as a nop, no register or memory writes.
- Supported funcs: add 100000 -> ALUC 010, sub 100010 -> 110, and 100100 -> 000, or 100101 -> 001, slt 101010 -> 111.
- EX_R: ALUSrcA=1, ALUSrcB=0, ALUC from func, WriteC=1. Next WB_R.
- WB_R: RegDst=1, MemToReg=0, WriteReg=1. Next IF.
- EX_MEMADR: ALUSrcA=1, ALUSrcB=1, ALUC=010, WriteC=1. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD: IorD=1, WriteDR=1. Next WB_LW.
- WB_LW: RegDst=0, MemToReg=1, WriteReg=1. Next IF.
- MEM_WR: IorD=1, WriteMem=1. Next IF.
- EX_BEQ: ALUSrcA=1, ALUSrcB=0, ALUC=110, PCSource=01, WritePC=Zero (the only Mealy output). Next IF.
- EX_J: PCSource=10, WritePC=1. Next IF.
- EX_I: ALUSrcA=1, ALUSrcB=1, ALUC=010, WriteC=1. Next WB_I.
- WB_I: RegDst=0, MemToReg=0, WriteReg=1. Next IF.
- Cycle counts: R/addi/sw = 4, lw = 5, beq/j = 3, unsupported = 2.
- insn_type and insn_code are combinational from op/func.
- insn_stage=1 in WB_R, WB_LW, MEM_WR, EX_BEQ, EX_J, WB_I, and in ID when the instruction is unsupported.
- rst asserted mid-instruction aborts the instruction; IF is entered on the next edge.

Optional Feature:
CTRL_ADDI_EN: when defined, addi is supported (EX_I and WB_I exist, insn_code=1 for op 001000). When undefined, op 001000 is unsupported (insn_code=0, ID->IF), and states 10/11 are illegal.

Decomposition:
- Package ctrl_pkg holds the state encodings, opcode/func constants, ALUC codes and PCSource codes.
- One natural sub-module: alu_ctrl_dec (func -> ALUC plus func-valid flag).

Test Plan:
- rst=1 for one edge, then release -> state_out=0; in IF, WriteIR=WritePC=1, PCSource=00, all other enables 0.
- op=000000, func=100000, Zero=0 -> state sequence 0,1,2,6,0; ALUC=010 in EX_R; WriteReg=1 with RegDst=1 in WB_R; insn_type=1, insn_code=1.
- op=100011 -> 0,1,3,4,7,0 with IorD=1 and WriteDR=1 in state 4, MemToReg=1 in state 7. op=101011 -> 0,1,3,5,0 with WriteMem=1 only in state 5.
- op=000100 with Zero=1 -> WritePC=1, PCSource=01 in state 8; with Zero=0 -> WritePC=0. op=000010 -> state 9 with WritePC=1, PCSource=10.
- op=111111 -> 0,1,0; insn_code=0, insn_stage=1 in ID, no writes. rst asserted in state 4 -> state 0 after the next edge.
- op=001000 -> 0,1,10,11,0 with CTRL_ADDI_EN defined; 0,1,0 without it.
